rcc_div_ratio_det: RTL and testbench

- Receive-side checker for the RCC dynamic clock divider.
- Watches the divider's per-period enable pulse in the source clock domain, measures the interval between pulses, and recovers the 3-bit divide-select code the divider is running at (1/2/4/8/16).
- Used by RCC status/debug logic to confirm that a requested div_sel change has taken effect, and to flag illegal periods or a stalled divider.

---
 rtl/rcc_div_ratio_det.sv | 119 +++++++++++
 tb/tb_rcc_div_ratio_det.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rcc_div_ratio_det.sv
// rcc_div_ratio_det: recovers the RCC divider select code from the spacing of its enable pulses
module rcc_div_ratio_det #(
    parameter int CNT_WID  = 6,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    output logic [2:0] det_sel,
    output logic       det_valid,
    output logic       det_chg,
    output logic       err_illegal,
    output logic       err_timeout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEAS = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;
    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [CNT_WID-1:0] TO_LAST = CNT_WID'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_WID-1:0] cnt_q, cnt_d;
    logic [2:0]         cand_q, cand_d;
    logic [3:0]         match_q, match_d;
    logic [2:0]         sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               chg_q, chg_d;
    logic               ill_q, ill_d;
    logic               to_q, to_d;
    logic               legal, same;
    logic [2:0]         code;

    // cnt_q holds period-1 on the tick cycle
    assign legal = cnt_q == CNT_WID'(0) || cnt_q == CNT_WID'(1) || cnt_q == CNT_WID'(3) ||
                   cnt_q == CNT_WID'(7) || cnt_q == CNT_WID'(15);
    assign code  = cnt_q == CNT_WID'(0) ? 3'b000 :
                   cnt_q == CNT_WID'(1) ? 3'b100 :
                   cnt_q == CNT_WID'(3) ? 3'b101 :
                   cnt_q == CNT_WID'(7) ? 3'b110 : 3'b111;
    assign same  = match_q != 4'd0 && cand_q == code;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        match_d = match_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        chg_d   = 1'b0;
        ill_d   = 1'b0;
        to_d    = 1'b0;
        if (state_q == S_IDLE) begin
            cnt_d   = '0;
            state_d = tick ? S_MEAS : S_IDLE;
        end else if (tick) begin
            cnt_d = '0;
            if (!legal) begin
                ill_d   = 1'b1;
                match_d = 4'd0;
                cand_d  = 3'b000;
                valid_d = 1'b0;
                state_d = S_MEAS;
            end else begin
                match_d = same ? (match_q == LOCK_N ? match_q : match_q + 4'd1) : 4'd1;
                cand_d  = code;
                if (!same) begin
                    valid_d = 1'b0;
                    state_d = S_MEAS;
                end
                if (state_q == S_MEAS && match_d == LOCK_N) begin
                    state_d = S_LOCK;
                    valid_d = 1'b1;
                    sel_d   = code;
                    chg_d   = 1'b1;
                end
            end
        end else if (cnt_q == TO_LAST) begin
            to_d    = 1'b1;
            valid_d = 1'b0;
            match_d = 4'd0;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else begin
            cnt_d = cnt_q + CNT_WID'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst || !en) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= 3'b000;
            match_q <= 4'd0;
            sel_q   <= 3'b000;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end

    assign det_sel     = sel_q;
    assign det_valid   = valid_q;
    assign det_chg     = chg_q;
    assign err_illegal = ill_q;
    assign err_timeout = to_q;
endmodule

// File: tb/tb_rcc_div_ratio_det.sv
// tb_rcc_div_ratio_det: scoreboard bench; expected output vectors queued per driven cycle, popped after the edge
module tb_rcc_div_ratio_det;
    localparam int NONE = 0, LOCK = 1, DROP = 2, ILL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] sel0, sel1;
    logic       val0, chg0, ill0, to0, val1, chg1, ill1, to1;

    int         checks = 0;
    int         failures = 0;
    int         which = 0;
    string      phase = "reset";
    logic [2:0] exp_sel = 3'b000;
    logic       exp_valid = 1'b0;
    logic [6:0] sb[$];

    always #5 clk = ~clk;

    rcc_div_ratio_det dut0 (
        .i_clk(clk), .rst(rst), .en(en), .tick(tick),
        .det_sel(sel0), .det_valid(val0), .det_chg(chg0),
        .err_illegal(ill0), .err_timeout(to0)
    );

    rcc_div_ratio_det #(.LOCK_CNT(1)) dut1 (
        .i_clk(clk), .rst(rst), .en(en), .tick(tick),
        .det_sel(sel1), .det_valid(val1), .det_chg(chg1),
        .err_illegal(ill1), .err_timeout(to1)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t obs{sel,valid,chg,ill,to}=%b exp=%b", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [2:0] code_of(input int p);
        return p == 1 ? 3'b000 : p == 2 ? 3'b100 : p == 4 ? 3'b101 : p == 8 ? 3'b110 : 3'b111;
    endfunction

    task automatic cyc(input logic t, input logic c, input logic il, input logic to);
        logic [6:0] obs;
        tick = t;
        sb.push_back({exp_sel, exp_valid, c, il, to});
        @(posedge clk);
        #1;
        obs = which != 0 ? {sel1, val1, chg1, ill1, to1} : {sel0, val0, chg0, ill0, to0};
        chk(phase, obs, sb.pop_front());
    endtask

    task automatic per(input int p, input int ev);
        for (int i = 1; i < p; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        if (ev == LOCK) begin
            exp_valid = 1'b1;
            exp_sel   = code_of(p);
        end else if (ev != NONE) begin
            exp_valid = 1'b0;
        end
        cyc(1'b1, ev == LOCK, ev == ILL, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        phase = tag;
        rst = 1'b1;
        exp_sel = 3'b000;
        exp_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic steady(input int p, input string tag);
        phase = tag;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) per(p, NONE);
        per(p, LOCK);
        per(p, NONE);
        per(p, NONE);
    endtask

    initial begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset("reset");
        steady(2, "steady2");
        phase = "illegal";
        per(3, ILL);
        for (int i = 0; i < 3; i++) per(2, NONE);
        per(2, LOCK);
        phase = "tick_on_timeout";
        per(32, ILL);
        for (int i = 0; i < 3; i++) per(2, NONE);
        per(2, LOCK);
        do_reset("reset2");
        steady(4, "steady4");
        phase = "switch16";
        per(16, DROP);
        per(16, NONE);
        per(16, NONE);
        per(16, LOCK);
        per(16, NONE);
        phase = "timeout";
        for (int i = 0; i < 31; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        steady(16, "after_timeout");
        do_reset("reset3");
        steady(8, "steady8");
        do_reset("reset_midlock");
        steady(8, "rearm8");
        do_reset("reset4");
        steady(16, "steady16");
        do_reset("reset5");
        steady(1, "steady1");
        phase = "en_off";
        en = 1'b0;
        exp_sel = 3'b000;
        exp_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        which = 1;
        do_reset("lc1_reset");
        phase = "lc1_lock";
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        per(8, LOCK);
        per(8, NONE);
        phase = "lc1_en_off";
        en = 1'b0;
        exp_sel = 3'b000;
        exp_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        phase = "lc1_relock";
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        per(8, LOCK);
        per(8, NONE);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
